// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order memory requests and
// presents buffered instructions to decode; redirects flush the buffer and drop stale responses.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        ID_ready,
   output logic        IF_valid,
   output logic [31:0] IF_IR,
   output logic [31:0] IF_PC
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int OW = CW + 1;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] PC0 = {RESET_PC[31:2], 2'b00};

   typedef enum logic [1:0] {S_WAIT, S_FETCH, S_FLUSH} state_t;
   state_t state, state_next;

   logic [31:0]   fetch_pc;
   logic [CW-1:0] outstanding, outstanding_next, count;
   logic [PW-1:0] head, tail, iss_rd, iss_wr;
   logic [31:0]   fifo_pc [DEPTH];
   logic [31:0]   fifo_ir [DEPTH];
   logic [31:0]   iss_pc  [DEPTH];
   logic          pop, grant, resp, keep, redirect_eff;
   logic [OW-1:0] occupancy;
   logic          unused_ok;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign unused_ok        = ^redirect_pc[1:0];
   assign redirect_eff     = redirect && (state != S_WAIT);
   assign pop              = IF_valid && ID_ready;
   assign occupancy        = OW'(outstanding) + OW'(count) - OW'(pop);
   assign grant            = imem_req && imem_gnt;
   // A response with nothing outstanding can only be a leftover from before reset.
   assign resp             = imem_rvalid && (outstanding != '0);
   assign keep             = resp && (state == S_FETCH) && !redirect_eff;
   assign outstanding_next = outstanding + CW'(grant) - CW'(resp);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_WAIT;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_WAIT:  state_next = S_FETCH;
         S_FETCH: begin
            if (redirect_eff)
               state_next = (outstanding_next == '0) ? S_FETCH : S_FLUSH;
         end
         S_FLUSH: begin
            if (outstanding_next == '0)
               state_next = S_FETCH;
         end
         default: state_next = S_WAIT;
      endcase
   end

   always_comb begin
      imem_req = 1'b0;
      if (state == S_FETCH)
         imem_req = !redirect && (occupancy < OW'(DEPTH));
   end

   assign imem_addr = fetch_pc;
   assign IF_valid  = (count != '0);
   assign IF_IR     = IF_valid ? fifo_ir[head] : NOP;
   assign IF_PC     = IF_valid ? fifo_pc[head] : 32'h0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc    <= PC0;
         outstanding <= '0;
         count       <= '0;
         head        <= '0;
         tail        <= '0;
         iss_rd      <= '0;
         iss_wr      <= '0;
      end else begin
         outstanding <= outstanding_next;
         if (grant) iss_wr <= ptr_inc(iss_wr);
         if (resp)  iss_rd <= ptr_inc(iss_rd);
         // Redirect wins over pop and buffering; grant cannot coincide since imem_req is low.
         if (redirect_eff) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            count    <= '0;
            head     <= tail;
         end else begin
            if (grant) fetch_pc <= fetch_pc + 32'd4;
            if (keep)  tail <= ptr_inc(tail);
            if (pop)   head <= ptr_inc(head);
            count <= count + CW'(keep) - CW'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (grant)
         iss_pc[iss_wr] <= fetch_pc;
      if (keep) begin
         fifo_pc[tail] <= iss_pc[iss_rd];
         fifo_ir[tail] <= imem_rdata;
      end
   end
endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: start-up, streaming, stall, flush, redirect, wrap and async reset.
module tb_if_fetch_stage;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b1;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        ID_ready = 1'b0;
   logic        IF_valid;
   logic [31:0] IF_IR, IF_PC;

   logic        w_req;
   logic [31:0] w_addr;
   logic        w_rvalid = 1'b0;
   logic [31:0] w_rdata = 32'h0;
   logic        w_valid;
   logic [31:0] w_ir, w_pc;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   if_fetch_stage #(.RESET_PC(32'h0), .DEPTH(2)) dut (
      .clk(clk), .reset(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc), .ID_ready(ID_ready),
      .IF_valid(IF_valid), .IF_IR(IF_IR), .IF_PC(IF_PC));

   if_fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_wrap (
      .clk(clk), .reset(rst_n), .imem_req(w_req), .imem_addr(w_addr),
      .imem_gnt(1'b1), .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
      .redirect(1'b0), .redirect_pc(32'h0), .ID_ready(1'b1),
      .IF_valid(w_valid), .IF_IR(w_ir), .IF_PC(w_pc));

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_0003;
   endfunction

   // Memory model: grants sampled mid-cycle, response driven lat cycles after the grant cycle.
   int          lat = 1;
   int          cyc = 0;
   logic [31:0] q_addr[$];
   int          q_due[$];
   logic        g_s = 1'b0, wg_s = 1'b0;
   logic [31:0] ga_s = 32'h0, wga_s = 32'h0;

   always @(negedge clk) begin
      g_s   = imem_req & imem_gnt;
      ga_s  = imem_addr;
      wg_s  = w_req;
      wga_s = w_addr;
   end

   always @(posedge clk) begin
      #1;
      cyc++;
      w_rvalid = wg_s;
      w_rdata  = mem_word(wga_s);
      if (!rst_n) begin
         q_addr.delete();
         q_due.delete();
         imem_rvalid = 1'b0;
      end else begin
         if (g_s) begin
            q_addr.push_back(ga_s);
            q_due.push_back(cyc + lat - 1);
         end
         if (q_due.size() > 0 && q_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(q_addr[0]);
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
         end else begin
            imem_rvalid = 1'b0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench in cycle 0 (first cycle after release).
   task automatic do_reset(input int l, input logic rdy);
      step();
      rst_n = 1'b0; redirect = 1'b0; ID_ready = rdy; lat = l;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      step();
      rst_n = 1'b0; ID_ready = 1'b1; lat = 1; redirect = 1'b0;
      @(negedge clk);
      n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req got=%b exp=0", imem_req); end
      n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
      n_cmp++; if (IF_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got=%b exp=0", IF_valid); end
      n_cmp++; if (IF_IR !== NOP) begin n_bad++; $display("FAIL rst_ir got=%h exp=%h", IF_IR, NOP); end
      n_cmp++; if (IF_PC !== 32'h0) begin n_bad++; $display("FAIL rst_pc got=%h exp=0", IF_PC); end
      step();
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL wait_req got=%b exp=0", imem_req); end
      step(); @(negedge clk);
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         n_bad++; $display("FAIL first_req got=%b/%h exp=1/00000000", imem_req, imem_addr); end
      step(); @(negedge clk);
      n_cmp++; if (IF_valid !== 1'b0) begin n_bad++; $display("FAIL early_valid got=%b exp=0", IF_valid); end
      step(); @(negedge clk);
      n_cmp++; if (IF_valid !== 1'b1 || IF_PC !== 32'h0 || IF_IR !== mem_word(32'h0)) begin
         n_bad++; $display("FAIL first_insn got=%b/%h/%h exp=1/00000000/%h", IF_valid, IF_PC, IF_IR, mem_word(32'h0)); end
      $display("test_reset done");
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_pc [3];
      exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC;
      for (int k = 0; k < 3; k++) begin
         step(); @(negedge clk);
         n_cmp++; if (IF_valid !== 1'b1 || IF_PC !== exp_pc[k] || IF_IR !== mem_word(exp_pc[k])) begin
            n_bad++; $display("FAIL b2b[%0d] got=%b/%h/%h exp=1/%h/%h", k, IF_valid, IF_PC, IF_IR, exp_pc[k], mem_word(exp_pc[k])); end
      end
      $display("test_back_to_back done");
   endtask

   task automatic test_stall();
      logic [31:0] exp_pc [4];
      exp_pc[0] = 32'h10; exp_pc[1] = 32'h14; exp_pc[2] = 32'h18; exp_pc[3] = 32'h1C;
      for (int k = 0; k < 6; k++) begin
         step(); ID_ready = 1'b0; @(negedge clk);
         n_cmp++; if (IF_valid !== 1'b1 || IF_PC !== 32'h10 || IF_IR !== mem_word(32'h10)) begin
            n_bad++; $display("FAIL stall_hold[%0d] got=%b/%h/%h exp=1/00000010/%h", k, IF_valid, IF_PC, IF_IR, mem_word(32'h10)); end
         if (k == 5) begin
            n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL stall_req got=%b exp=0", imem_req); end
         end
      end
      for (int k = 0; k < 4; k++) begin
         step(); ID_ready = 1'b1; @(negedge clk);
         n_cmp++; if (IF_valid !== 1'b1 || IF_PC !== exp_pc[k]) begin
            n_bad++; $display("FAIL drain[%0d] got=%b/%h exp=1/%h", k, IF_valid, IF_PC, exp_pc[k]); end
      end
      $display("test_stall done");
   endtask

   task automatic test_flush();
      do_reset(3, 1'b1);
      step(); step(); step();
      redirect = 1'b1; redirect_pc = 32'h100;
      @(negedge clk);
      n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL flush_redir_req got=%b exp=0", imem_req); end
      for (int c = 4; c <= 10; c++) begin
         step(); redirect = 1'b0; @(negedge clk);
         if (c <= 5) begin
            n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL flush_req_c%0d got=%b exp=0", c, imem_req); end
         end
         if (c == 6) begin
            n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
               n_bad++; $display("FAIL flush_refetch got=%b/%h exp=1/00000100", imem_req, imem_addr); end
         end
         if (c <= 9) begin
            n_cmp++; if (IF_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid_c%0d got=%b exp=0", c, IF_valid); end
         end else begin
            n_cmp++; if (IF_valid !== 1'b1 || IF_PC !== 32'h100 || IF_IR !== mem_word(32'h100)) begin
               n_bad++; $display("FAIL flush_target got=%b/%h/%h exp=1/00000100/%h", IF_valid, IF_PC, IF_IR, mem_word(32'h100)); end
         end
      end
      $display("test_flush done");
   endtask

   task automatic test_redirect_pop();
      do_reset(1, 1'b1);
      step(); step(); step(); step();
      redirect = 1'b1; redirect_pc = 32'h203;
      @(negedge clk);
      n_cmp++; if (IF_valid !== 1'b1 || IF_PC !== 32'h4 || imem_req !== 1'b0) begin
         n_bad++; $display("FAIL rp_cycle got=%b/%h/req%b exp=1/00000004/req0", IF_valid, IF_PC, imem_req); end
      step(); redirect = 1'b0; @(negedge clk);
      n_cmp++; if (IF_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
         n_bad++; $display("FAIL rp_next got=%b/req%b/%h exp=0/req1/00000200", IF_valid, imem_req, imem_addr); end
      step(); @(negedge clk);
      n_cmp++; if (IF_valid !== 1'b0) begin n_bad++; $display("FAIL rp_gap got=%b exp=0", IF_valid); end
      step(); @(negedge clk);
      n_cmp++; if (IF_valid !== 1'b1 || IF_PC !== 32'h200 || IF_IR !== mem_word(32'h200)) begin
         n_bad++; $display("FAIL rp_target got=%b/%h/%h exp=1/00000200/%h", IF_valid, IF_PC, IF_IR, mem_word(32'h200)); end
      $display("test_redirect_pop done");
   endtask

   task automatic test_wrap();
      logic [31:0] exp_pc [3];
      exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0;
      do_reset(1, 1'b1);
      step(); step(); step();
      for (int k = 0; k < 3; k++) begin
         if (k > 0) step();
         @(negedge clk);
         n_cmp++; if (w_valid !== 1'b1 || w_pc !== exp_pc[k]) begin
            n_bad++; $display("FAIL wrap[%0d] got=%b/%h exp=1/%h", k, w_valid, w_pc, exp_pc[k]); end
      end
      $display("test_wrap done");
   endtask

   task automatic test_async_reset();
      do_reset(1, 1'b0);
      step(); step(); step(); step(); step();
      ID_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (IF_valid !== 1'b1 || imem_req !== 1'b1 || IF_PC !== 32'h0) begin
         n_bad++; $display("FAIL ar_pre got=%b/req%b/%h exp=1/req1/00000000", IF_valid, imem_req, IF_PC); end
      #1 rst_n = 1'b0;
      #1;
      n_cmp++; if (IF_valid !== 1'b0 || imem_req !== 1'b0 || IF_IR !== NOP || IF_PC !== 32'h0 || imem_addr !== 32'h0) begin
         n_bad++; $display("FAIL ar_immediate got=%b/req%b/%h/%h/%h exp=0/req0/%h/0/0", IF_valid, imem_req, IF_IR, IF_PC, imem_addr, NOP); end
      step(); step();
      rst_n = 1'b1;
      step(); @(negedge clk);
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         n_bad++; $display("FAIL ar_refetch got=%b/%h exp=1/00000000", imem_req, imem_addr); end
      step(); step(); @(negedge clk);
      n_cmp++; if (IF_valid !== 1'b1 || IF_PC !== 32'h0) begin
         n_bad++; $display("FAIL ar_first got=%b/%h exp=1/00000000", IF_valid, IF_PC); end
      $display("test_async_reset done");
   endtask

   initial begin
      #200000;
      $display("FAIL timeout compared=%0d", n_cmp);
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_back_to_back();
      test_stall();
      test_flush();
      test_redirect_pop();
      test_wrap();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
